// File: rtl/id_token_collector_pkg.sv
// Shared definitions for the identifier token collector: FSM encoding,
// ASCII class bounds and the run-length saturation limit.
package id_token_collector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0] CH_0    = 8'h30;  // "0"
  localparam logic [7:0] CH_9    = 8'h39;  // "9"
  localparam logic [7:0] CH_UA   = 8'h41;  // "A"
  localparam logic [7:0] CH_UZ   = 8'h5A;  // "Z"
  localparam logic [7:0] CH_LA   = 8'h61;  // "a"
  localparam logic [7:0] CH_LZ   = 8'h7A;  // "z"
  localparam logic [7:0] LEN_MAX = 8'd255;

endpackage

// File: rtl/id_token_collector_char_class.sv
// Combinational ASCII classifier: flags letters and decimal digits.
module char_class
  import id_token_collector_pkg::*;
(
  input  logic [7:0] char,
  output logic       is_alpha,
  output logic       is_digit
);

  always_comb begin
    is_digit = (char >= CH_0) && (char <= CH_9);
    is_alpha = ((char >= CH_UA) && (char <= CH_UZ)) ||
               ((char >= CH_LA) && (char <= CH_LZ));
  end

endmodule

// File: rtl/id_token_collector.sv
// Collects identifier tokens from a character stream into a single-entry
// output buffer. Optional TOKEN_MAXLEN_EN adds a max_len high-water output.
module id_token_collector
  import id_token_collector_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  char,
  input  logic        match,
  output logic        tok_valid,
  output logic [7:0]  tok_len,
  input  logic        tok_ready,
  output logic [15:0] tok_count,
  output logic        drop
`ifdef TOKEN_MAXLEN_EN
  ,
  output logic [7:0]  max_len
`endif
);

  state_e      state_q, state_d;
  logic [7:0]  run_len_q, run_len_d;
  logic        buf_valid_q, buf_valid_d;
  logic [7:0]  tok_len_q, tok_len_d;
  logic [15:0] tok_count_q, tok_count_d;
  logic        drop_q, drop_d;

  logic is_alpha, is_digit, is_alnum;
  logic complete, release_buf, write_buf;

  char_class u_char_class (
    .char     (char),
    .is_alpha (is_alpha),
    .is_digit (is_digit)
  );

  assign is_alnum = is_alpha | is_digit;

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    drop_d      = drop_q;
    tok_count_d = tok_count_q;
    tok_len_d   = tok_len_q;

    complete    = in_valid && (state_q == RUN) && !is_alnum && match;
    release_buf = buf_valid_q && tok_ready;
    // A full buffer can still accept a token if it drains on this edge.
    write_buf   = complete && (!buf_valid_q || tok_ready);

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (is_alnum) begin
            state_d   = RUN;
            run_len_d = 8'd1;
          end
        end
        RUN: begin
          if (is_alnum) begin
            run_len_d = (run_len_q == LEN_MAX) ? LEN_MAX : run_len_q + 8'd1;
          end else begin
            state_d   = IDLE;
            run_len_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete && !write_buf) drop_d = 1'b1;

    if (write_buf) begin
      buf_valid_d = 1'b1;
      tok_len_d   = run_len_q;
      tok_count_d = tok_count_q + 16'd1;
    end else if (release_buf) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      run_len_q   <= 8'd0;
      buf_valid_q <= 1'b0;
      tok_len_q   <= 8'd0;
      tok_count_q <= 16'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      buf_valid_q <= buf_valid_d;
      tok_len_q   <= tok_len_d;
      tok_count_q <= tok_count_d;
      drop_q      <= drop_d;
    end
  end

`ifdef TOKEN_MAXLEN_EN
  logic [7:0] max_len_q, max_len_d;

  always_comb begin
    max_len_d = max_len_q;
    if (write_buf && (run_len_q > max_len_q)) max_len_d = run_len_q;
  end

  always_ff @(posedge clk) begin
    if (reset) max_len_q <= 8'd0;
    else       max_len_q <= max_len_d;
  end

  assign max_len = max_len_q;
`endif

  assign tok_valid = buf_valid_q;
  assign tok_len   = tok_len_q;
  assign tok_count = tok_count_q;
  assign drop      = drop_q;

endmodule

// File: doc/id_token_collector.md
ID_TOKEN_COLLECTOR -- requirements
Module: id_token_collector

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: in_valid  input  1  char and match are meaningful this cycle.
REQ-004 SHALL have port: char  input  8  ASCII character of the stream.
REQ-005 SHALL have port: match  input  1  identifier-recognizer output; high = the alnum run so far (excluding char this cycle) is letters followed by one or more digits.
REQ-006 SHALL have port: tok_valid  output  1  a completed identifier token is held in the output buffer.
REQ-007 SHALL have port: tok_len  output  8  length of the held token; saturating.
REQ-008 SHALL have port: tok_ready  input  1  consumer accepts the token when tok_valid && tok_ready.
REQ-009 SHALL have port: tok_count  output  16  number of tokens written into the output buffer since reset; wraps.
REQ-010 SHALL have port: drop  output  1  sticky; a completed token was lost because the buffer was full.
REQ-011 SHALL have port (TOKEN_MAXLEN_EN only): max_len  output  8  largest tok_len written since reset.

Function
REQ-012 SHALL classify char as alnum when it is in "0".."9", "A".."Z" or "a".."z"; any other value is a delimiter.
REQ-013 SHALL implement FSM states IDLE and RUN; cycles with in_valid=0 change no state, counter or flag.
REQ-014 IDLE, valid alnum: SHALL go to RUN, run_len=1.
REQ-015 IDLE, valid delimiter: SHALL stay IDLE and emit nothing.
REQ-016 RUN, valid alnum: SHALL stay RUN, run_len+1, saturating at 255.
REQ-017 RUN, valid delimiter: SHALL go to IDLE; if match=1 the run completes a token of length run_len; if match=0 nothing is emitted.
REQ-018 A completed token SHALL be written into the single-entry buffer at the same clock edge; tok_valid rises the following cycle (1-cycle latency from delimiter to tok_valid).
REQ-019 Buffer SHALL release its entry on a cycle with tok_valid && tok_ready; tok_len stays stable while tok_valid && !tok_ready.
REQ-020 Completion while the buffer is full and tok_ready=1 in that same cycle: SHALL drain and reload in one edge; tok_valid stays 1 with the new tok_len; drop is not set.
REQ-021 Completion while the buffer is full and tok_ready=0: SHALL discard the new token, set drop=1, and leave tok_count unchanged.
REQ-022 tok_count SHALL increment by 1 per token written into the buffer; it wraps from 0xFFFF to 0x0000.
REQ-023 match SHALL be ignored in every case except REQ-017.
REQ-024 An end of stream without a delimiter SHALL leave the run pending; it does not emit.

Reset
REQ-025 reset=1 SHALL force, at the next edge: state=IDLE, run_len=0, tok_valid=0, tok_len=0, tok_count=0, drop=0, max_len=0.
REQ-026 reset SHALL take priority over every other input in the same cycle, including mid-RUN and a pending buffered token, which is lost.

Configuration
REQ-027 Macro TOKEN_MAXLEN_EN defined: SHALL provide max_len, updated to tok_len whenever a written token exceeds it.
REQ-028 Macro TOKEN_MAXLEN_EN undefined: SHALL have no max_len port and no associated register; all other behaviour is identical.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1), the ASCII bound constants ("0","9","A","Z","a","z"), and the saturation limit 255.
REQ-030 Character classification SHALL be a combinational sub-module char_class (char -> is_alpha, is_digit); the block instantiates it once.

Verification
REQ-031 Bench SHALL cover: stream "ab12 " with match high on the space cycle, tok_ready=1 -> tok_valid for 1 cycle the cycle after the space, tok_len=4, tok_count=1.
REQ-032 Bench SHALL cover: stream "abc " with match=0 on the space -> no tok_valid, tok_count=0.
REQ-033 Bench SHALL cover: tokens "a1 " and "b22 " with tok_ready=0 -> first token held with tok_len=2; second dropped; drop=1; tok_count=1.
REQ-034 Bench SHALL cover: the REQ-033 setup with tok_ready=1 in the second delimiter cycle -> tok_len=3, drop=0, tok_count=2.
REQ-035 Bench SHALL cover: 300 letters, then "9 ", with match=1 -> tok_len=255 (saturated); with TOKEN_MAXLEN_EN defined, max_len=255.
REQ-036 Bench SHALL cover: reset asserted mid-run of "xy7" and on a held token -> next cycle tok_valid=0, tok_count=0, state IDLE; then "q5 " -> tok_len=2.
